ofdm_packet_framer: RTL

Segments the synchronized, phase-parallel sample stream from the synchronizer into preamble and payload fields (STF, LTF, DATA symbols) for downstream channel estimation and FFT. It tracks packet position by beat counting, tags every output beat with its field, symbol index and FFT-window boundaries, and detects truncated packets. It sits directly after the synchronizer in the receive top level and is a fully parametrised replacement for hard-coded 64/16/12 packet framing.

---
 rtl/ofdm_packet_framer.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ofdm_packet_framer.sv
// ofdm_packet_framer
// Segments the synchronized, phase-parallel sample stream into STF, LTF and
// DATA fields by beat counting. Every output beat is tagged with its field,
// DATA symbol index, cyclic-prefix flag and FFT-window boundaries. A beat
// that goes invalid mid-packet aborts the packet with a one-cycle err_o.
// After a complete packet the framer drains until it sees one invalid beat,
// so a continuously held valid cannot re-trigger a new packet.
//
// Build option: define FRAMER_CP_STRIP_EN to suppress cyclic-prefix beats
// (valid_o=0, cp_o=0). Without it CP beats are emitted with cp_o=1.
module ofdm_packet_framer #(
  parameter int DATAWIDTH = 16,
  parameter int PHASES    = 16,
  parameter int FFT_SIZE  = 64,
  parameter int CP_LEN    = 16,
  parameter int NUMSYMB   = 12,
  parameter int STF_LEN   = 160,
  parameter int LTF_LEN   = 160
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [DATAWIDTH*PHASES-1:0]         re_i,
  input  logic [DATAWIDTH*PHASES-1:0]         im_i,
  input  logic [PHASES-1:0]                   valid_i,
  output logic [DATAWIDTH*PHASES-1:0]         data_re_o,
  output logic [DATAWIDTH*PHASES-1:0]         data_im_o,
  output logic                                valid_o,
  output logic [1:0]                          field_o,
  output logic                                cp_o,
  output logic [$clog2(NUMSYMB+1)-1:0]        sym_idx_o,
  output logic                                sof_o,
  output logic                                eof_o,
  output logic                                pkt_done_o,
  output logic                                err_o
);

  // Field lengths in clock beats.
  localparam int SB   = STF_LEN / PHASES;
  localparam int LB   = LTF_LEN / PHASES;
  localparam int CB   = CP_LEN / PHASES;
  localparam int FB   = FFT_SIZE / PHASES;
  localparam int MAXB = (SB > LB) ? ((SB > CB + FB) ? SB : CB + FB)
                                  : ((LB > CB + FB) ? LB : CB + FB);
  localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int SW   = $clog2(NUMSYMB + 1);

  localparam logic [BW-1:0] SB_LAST   = BW'(SB - 1);
  localparam logic [BW-1:0] LB_LAST   = BW'(LB - 1);
  localparam logic [BW-1:0] FFT_FIRST = BW'(CB);
  localparam logic [BW-1:0] DATA_LAST = BW'(CB + FB - 1);
  localparam logic [SW-1:0] SYM_LAST  = SW'(NUMSYMB - 1);

  // Reject configurations that cannot be framed on whole beats.
  generate
    if (PHASES < 1 || DATAWIDTH < 1) begin : g_bad_width
      $error("ofdm_packet_framer: PHASES and DATAWIDTH must be >= 1");
    end
    if (FFT_SIZE < PHASES || (FFT_SIZE % PHASES) != 0) begin : g_bad_fft
      $error("ofdm_packet_framer: FFT_SIZE must be a nonzero multiple of PHASES");
    end
    if (CP_LEN < 0 || (CP_LEN % PHASES) != 0) begin : g_bad_cp
      $error("ofdm_packet_framer: CP_LEN must be a multiple of PHASES");
    end
    if (NUMSYMB < 1) begin : g_bad_numsymb
      $error("ofdm_packet_framer: NUMSYMB must be >= 1");
    end
    if (STF_LEN < PHASES || (STF_LEN % PHASES) != 0) begin : g_bad_stf
      $error("ofdm_packet_framer: STF_LEN must be a nonzero multiple of PHASES");
    end
    if (LTF_LEN < PHASES || (LTF_LEN % PHASES) != 0) begin : g_bad_ltf
      $error("ofdm_packet_framer: LTF_LEN must be a nonzero multiple of PHASES");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_STF,
    S_LTF,
    S_DATA,
    S_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    F_NONE = 2'd0,
    F_STF  = 2'd1,
    F_LTF  = 2'd2,
    F_DATA = 2'd3
  } field_t;

  state_t        state;
  logic [BW-1:0] cnt;
  logic [SW-1:0] sym;
  logic          beat_ok;
  logic          in_cp;
  logic          is_sof;
  logic          is_eof;

  // A beat counts only when every phase is valid.
  assign beat_ok = &valid_i;
  assign is_sof  = (cnt == FFT_FIRST);
  assign is_eof  = (cnt == DATA_LAST);

  // Position inside a DATA symbol: the first CB beats are cyclic prefix.
  generate
    if (CB > 0) begin : g_cp
      assign in_cp = (cnt < FFT_FIRST);
    end else begin : g_no_cp
      assign in_cp = 1'b0;
    end
  endgenerate

  // Sample pipeline: one-beat registered copy of the input samples.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      data_re_o <= '0;
      data_im_o <= '0;
    end else begin
      data_re_o <= re_i;
      data_im_o <= im_i;
    end
  end

  // Framing FSM with registered tags and pulses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sym        <= '0;
      valid_o    <= 1'b0;
      field_o    <= F_NONE;
      cp_o       <= 1'b0;
      sym_idx_o  <= '0;
      sof_o      <= 1'b0;
      eof_o      <= 1'b0;
      pkt_done_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      // NOTE: defaults first keep pulses single-cycle and tags zero when idle.
      valid_o    <= 1'b0;
      field_o    <= F_NONE;
      cp_o       <= 1'b0;
      sym_idx_o  <= '0;
      sof_o      <= 1'b0;
      eof_o      <= 1'b0;
      pkt_done_o <= 1'b0;
      err_o      <= 1'b0;

      case (state)
        S_IDLE: begin
          // The triggering beat is STF beat 0; no dead cycle.
          if (beat_ok) begin
            valid_o <= 1'b1;
            field_o <= F_STF;
            if (SB == 1) begin
              state <= S_LTF;
              cnt   <= '0;
            end else begin
              state <= S_STF;
              cnt   <= BW'(1);
            end
          end
        end

        S_STF: begin
          if (!beat_ok) begin
            err_o <= 1'b1;
            state <= S_IDLE;
            cnt   <= '0;
            sym   <= '0;
          end else begin
            valid_o <= 1'b1;
            field_o <= F_STF;
            if (cnt == SB_LAST) begin
              state <= S_LTF;
              cnt   <= '0;
            end else begin
              cnt <= cnt + BW'(1);
            end
          end
        end

        S_LTF: begin
          if (!beat_ok) begin
            err_o <= 1'b1;
            state <= S_IDLE;
            cnt   <= '0;
            sym   <= '0;
          end else begin
            valid_o <= 1'b1;
            field_o <= F_LTF;
            if (cnt == LB_LAST) begin
              state <= S_DATA;
              cnt   <= '0;
              sym   <= '0;
            end else begin
              cnt <= cnt + BW'(1);
            end
          end
        end

        S_DATA: begin
          if (!beat_ok) begin
            err_o <= 1'b1;
            state <= S_IDLE;
            cnt   <= '0;
            sym   <= '0;
          end else begin
            if (in_cp) begin
`ifdef FRAMER_CP_STRIP_EN
              // Stripped: the CP beat is counted but not emitted.
              cp_o <= 1'b0;
`else
              valid_o   <= 1'b1;
              field_o   <= F_DATA;
              cp_o      <= 1'b1;
              sym_idx_o <= sym;
`endif
            end else begin
              valid_o   <= 1'b1;
              field_o   <= F_DATA;
              sym_idx_o <= sym;
              sof_o     <= is_sof;
              eof_o     <= is_eof;
            end

            if (is_eof) begin
              cnt <= '0;
              if (sym == SYM_LAST) begin
                pkt_done_o <= 1'b1;
                sym        <= '0;
                state      <= S_DRAIN;
              end else begin
                sym <= sym + SW'(1);
              end
            end else begin
              cnt <= cnt + BW'(1);
            end
          end
        end

        S_DRAIN: begin
          // Discard beats until one invalid beat re-arms the framer.
          if (!beat_ok) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          sym   <= '0;
        end
      endcase
    end
  end

endmodule
